instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the 20-bit three-address ISA (opcode, A, B, W fields). It fetches from a synchronous instruction memory, decodes, reads two operands from an internal register file, and issues them to the external datapath over a valid/ready handshake. It then writes the returned result back. It succeeds the combinational fetch/decode path by adding a program counter, a control FSM, branch/halt handling, and parametrised widths and depths.

## Interface
Parameters:
- OP_W, 5, opcode field width
- REG_ADDR_W, 5, register address field width; NUM_REGS = 2**REG_ADDR_W
- WORD_W, 20, register/data word width
- PC_W, 5, program counter width; instruction memory depth = 2**PC_W; PC_W ≤ REG_ADDR_W

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins execution at pc 0 from IDLE or HALTED
- imem_en  out  1  instruction read strobe
- imem_addr  out  PC_W  instruction address
- imem_rdata  in  OP_W+3*REG_ADDR_W  instruction, valid the cycle after imem_en
- op_valid  out  1  operands/opcode valid to datapath
- op_ready  in  1  datapath accepts
- op_code  out  OP_W  opcode issued
- op_a, op_b  out  WORD_W  operand values
- res_valid  in  1  result strobe from datapath
- res_data  in  WORD_W  result
- dbg_addr  in  REG_ADDR_W  debug register select
- dbg_data  out  WORD_W  combinational read of reg[dbg_addr]
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED

## Operation
- Instruction fields: opcode [OP_W-1:0], A next REG_ADDR_W bits, B next, W top.
- Reserved opcodes: OP_NOP=0, OP_BRZ=2**OP_W-2, OP_HALT=2**OP_W-1. All other opcodes are dispatched to the datapath.
- States:
  - IDLE: on start, pc←0, go to FETCH.
  - FETCH: imem_en=1, imem_addr=pc, go to DECODE.
  - DECODE: ir←imem_rdata; op_a/op_b registers←reg[A]/reg[B]. Then:
    - NOP: pc←pc+1, go to FETCH.
    - BRZ: if reg[A]==0, pc←B[PC_W-1:0], else pc←pc+1; go to FETCH.
    - HALT: go to HALTED; pc is held.
    - Otherwise go to ISSUE.
  - ISSUE: op_valid=1. op_code/op_a/op_b are held stable until op_valid&&op_ready, then go to WAIT. op_valid must never drop without a handshake.
  - WAIT: on res_valid, capture res_data, go to WRITE.
  - WRITE: reg[W]←result; pc←pc+1; go to FETCH.
  - HALTED: on start, pc←0, go to FETCH.
- pc wraps from 2**PC_W-1 to 0.
- res_valid outside WAIT is ignored. start outside IDLE/HALTED is ignored.
- Reset values: pc 0, all registers 0, state IDLE, imem_en 0, imem_addr 0, op_valid 0, op_code/op_a/op_b 0, busy 0, halted 0.
- Reset asserted mid-instruction aborts it: no register write, op_valid drops immediately (asynchronously).

## Timing
- ALU instruction: 5 cycles minimum (FETCH, DECODE, ISSUE with op_ready already high, WAIT with res_valid the next cycle, WRITE). Each op_ready or res_valid stall adds one cycle.
- NOP/BRZ: 2 cycles. HALT: 2 cycles to halted=1.
- A register written in WRITE is visible to the next instruction's DECODE; no forwarding is needed.
- dbg_data reflects a write the cycle after WRITE.
- Datapath contract: res_valid no earlier than one cycle after the op handshake.

## Configuration
- ISEQ_R0_ZERO_EN defined:
  - reg[0] is hardwired to 0.
  - Writes to W=0 are dropped.
  - Reads of address 0 (operands, BRZ test, dbg) return 0.
- Undefined: reg[0] is an ordinary register.

## Structure
- Package iseq_pkg holds:
  - state enum (IDLE, FETCH, DECODE, ISSUE, WAIT, WRITE, HALTED)
  - OP_NOP/OP_BRZ/OP_HALT constants (as functions of OP_W)
  - field offset localparams
- Sub-module iseq_regfile:
  - NUM_REGS×WORD_W, async active-low clear
  - one write port, three combinational read ports (A, B, dbg)
  - owns the ISEQ_R0_ZERO_EN logic
- The FSM, pc and instruction register stay in instr_sequencer.

## Test plan
- Reset then start; memory holds ADD r3,r1,r2 (r1=5, r2=7 preloaded by earlier datapath ops), datapath adds with op_ready=1 and 1-cycle res_valid → op handshake at cycle 3 after start, r3=12 via dbg, 5 cycles per instruction.
- Datapath holds op_ready=0 for 4 cycles → op_code/op_a/op_b stable and op_valid continuously high; handshake on the 5th cycle; total 9 cycles.
- BRZ A=r4 (0), B=9 at pc 3 → next imem_addr=9. With r4=1 → next imem_addr=4.
- pc 31 executes NOP → next fetch at 0. HALT at pc 6 → halted=1, busy=0, no further imem_en; start → fetch at 0.
- With ISEQ_R0_ZERO_EN, write 0x0ABCD to W=0 → dbg_addr=0 reads 0. Without it → reads 0x0ABCD.
- rst_n low during WAIT → op_valid 0 immediately, all regs 0, state IDLE; later res_valid ignored.

Source files
------------

// File: rtl/iseq_pkg.sv
// ============================================================================
//  iseq_pkg : shared types and constants for the instruction sequencer
//  Revision : 1.0
// ============================================================================
`default_nettype none

package iseq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_WRITE  = 3'd5,
        S_HALTED = 3'd6
    } state_e;

    // Instruction layout, LSB first: opcode | A | B | W
    localparam int unsigned C_OPC_LSB = 0;

    function automatic int unsigned fld_a_lsb(input int unsigned op_w);
        return op_w;
    endfunction

    function automatic int unsigned fld_b_lsb(input int unsigned op_w, input int unsigned ra_w);
        return op_w + ra_w;
    endfunction

    function automatic int unsigned fld_w_lsb(input int unsigned op_w, input int unsigned ra_w);
        return op_w + 2 * ra_w;
    endfunction

    function automatic int unsigned op_nop(input int unsigned op_w);
        return (op_w == 0) ? 0 : 0;
    endfunction

    function automatic int unsigned op_brz(input int unsigned op_w);
        return (1 << op_w) - 2;
    endfunction

    function automatic int unsigned op_halt(input int unsigned op_w);
        return (1 << op_w) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iseq_regfile.sv
// ============================================================================
//  iseq_regfile : NUM_REGS x WORD_W register file, 1 write / 3 read ports
//  Config macro : ISEQ_R0_ZERO_EN (register 0 hardwired to zero)
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module iseq_regfile #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WORD_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    output logic [WORD_W-1:0]     ra_data,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [WORD_W-1:0]     rb_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WORD_W-1:0]     dbg_data
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [WORD_W-1:0] regs_q [NUM_REGS];
    logic [WORD_W-1:0] regs_d [NUM_REGS];
    logic              w_we;

`ifdef ISEQ_R0_ZERO_EN
    assign w_we     = we && (waddr != '0);
    assign ra_data  = (ra_addr  == '0) ? '0 : regs_q[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs_q[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`else
    assign w_we     = we;
    assign ra_data  = regs_q[ra_addr];
    assign rb_data  = regs_q[rb_addr];
    assign dbg_data = regs_q[dbg_addr];
`endif

    always_comb begin
        regs_d = regs_q;
        if (w_we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
//  instr_sequencer : multi-cycle fetch/decode/issue/writeback sequencer
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
    import iseq_pkg::*;
#(
    parameter int unsigned OP_W       = 5,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WORD_W     = 20,
    parameter int unsigned PC_W       = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           imem_en,
    output logic [PC_W-1:0]                imem_addr,
    input  logic [OP_W+3*REG_ADDR_W-1:0]   imem_rdata,
    output logic                           op_valid,
    input  logic                           op_ready,
    output logic [OP_W-1:0]                op_code,
    output logic [WORD_W-1:0]              op_a,
    output logic [WORD_W-1:0]              op_b,
    input  logic                           res_valid,
    input  logic [WORD_W-1:0]              res_data,
    input  logic [REG_ADDR_W-1:0]          dbg_addr,
    output logic [WORD_W-1:0]              dbg_data,
    output logic                           busy,
    output logic                           halted
);

    localparam int unsigned IW      = OP_W + 3 * REG_ADDR_W;
    localparam int unsigned C_A_LSB = fld_a_lsb(OP_W);
    localparam int unsigned C_B_LSB = fld_b_lsb(OP_W, REG_ADDR_W);
    localparam int unsigned C_W_LSB = fld_w_lsb(OP_W, REG_ADDR_W);

    localparam logic [OP_W-1:0] C_OP_NOP  = OP_W'(op_nop(OP_W));
    localparam logic [OP_W-1:0] C_OP_BRZ  = OP_W'(op_brz(OP_W));
    localparam logic [OP_W-1:0] C_OP_HALT = OP_W'(op_halt(OP_W));

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [IW-1:0]       ir_q, ir_d;
    logic [WORD_W-1:0]   op_a_q, op_a_d;
    logic [WORD_W-1:0]   op_b_q, op_b_d;
    logic [WORD_W-1:0]   res_q, res_d;
    logic                w_rf_we;

    logic [OP_W-1:0]       w_fld_op;
    logic [REG_ADDR_W-1:0] w_fld_a, w_fld_b;
    logic [REG_ADDR_W-1:0] w_ra_addr, w_rb_addr;
    logic [WORD_W-1:0]     w_ra_data, w_rb_data;

    assign w_fld_op = imem_rdata[C_OPC_LSB +: OP_W];
    assign w_fld_a  = imem_rdata[C_A_LSB +: REG_ADDR_W];
    assign w_fld_b  = imem_rdata[C_B_LSB +: REG_ADDR_W];

    // Memory data is only meaningful in DECODE; elsewhere keep reading the held IR fields
    assign w_ra_addr = (state_q == S_DECODE) ? w_fld_a : ir_q[C_A_LSB +: REG_ADDR_W];
    assign w_rb_addr = (state_q == S_DECODE) ? w_fld_b : ir_q[C_B_LSB +: REG_ADDR_W];

    iseq_regfile #(
        .REG_ADDR_W (REG_ADDR_W),
        .WORD_W     (WORD_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_rf_we),
        .waddr    (ir_q[C_W_LSB +: REG_ADDR_W]),
        .wdata    (res_q),
        .ra_addr  (w_ra_addr),
        .ra_data  (w_ra_data),
        .rb_addr  (w_rb_addr),
        .rb_data  (w_rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        w_rf_we = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d   = imem_rdata;
                op_a_d = w_ra_data;
                op_b_d = w_rb_data;
                if (w_fld_op == C_OP_NOP) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end else if (w_fld_op == C_OP_BRZ) begin
                    pc_d    = (w_ra_data == '0) ? w_fld_b[PC_W-1:0] : pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end else if (w_fld_op == C_OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    res_d   = res_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                w_rf_we = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
        end
    end

    // Decoded straight from the state flop so reset drops op_valid without waiting for a clock
    assign op_valid  = (state_q == S_ISSUE);
    assign imem_en   = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign op_code   = ir_q[C_OPC_LSB +: OP_W];
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted    = (state_q == S_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
//  tb_instr_sequencer : scoreboard bench for instr_sequencer
//  Honours ISEQ_R0_ZERO_EN for the register-0 expectations.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    localparam int OPW = 5;
    localparam int RAW = 5;
    localparam int WW  = 20;
    localparam int PW  = 5;
    localparam int IW  = OPW + 3 * RAW;

    localparam int C_LDC  = 5;   // datapath returns next queued immediate
    localparam int C_ADD  = 1;
    localparam int C_SADD = 7;   // add, datapath stalls op_ready 4 cycles
    localparam int C_HANG = 9;   // accepted, never answered
    localparam int C_NRDY = 10;  // never accepted
    localparam int C_BRZ  = 30;
    localparam int C_HALT = 31;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           imem_en;
    logic [PW-1:0]  imem_addr;
    logic [IW-1:0]  imem_rdata = '0;
    logic           op_valid;
    logic           op_ready = 1'b1;
    logic [OPW-1:0] op_code;
    logic [WW-1:0]  op_a, op_b;
    logic           res_valid = 1'b0;
    logic [WW-1:0]  res_data = '0;
    logic [RAW-1:0] dbg_addr = '0;
    logic [WW-1:0]  dbg_data;
    logic           busy, halted;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_data(res_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int gap; } fetch_t;
    typedef struct { int code; int a; int b; int lat; } issue_t;

    fetch_t         fetch_q[$];
    issue_t         issue_q[$];
    logic [WW-1:0]  ld_q[$];
    logic [IW-1:0]  imem [32];
    int             n_chk = 0;
    int             n_pass = 0;
    int             cyc = 0;
    bit             inject_res = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [IW-1:0] enc(input logic [4:0] op, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] w);
        return {w, b, a, op};
    endfunction

    task automatic push_f(input int addr, input int gap);
        fetch_t f;
        f.addr = addr; f.gap = gap;
        fetch_q.push_back(f);
    endtask

    task automatic push_i(input int code, input int a, input int b, input int lat);
        issue_t e;
        e.code = code; e.a = a; e.b = b; e.lat = lat;
        issue_q.push_back(e);
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 32; i++) imem[i] = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic dbg_chk(input string tag, input int addr, input int exp);
        dbg_addr = addr[RAW-1:0];
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("halted_reached", halted, 1);
    endtask

    // Synchronous instruction memory
    initial begin
        forever begin
            @(posedge clk);
            if (imem_en) imem_rdata = imem[imem_addr];
        end
    end

    // Datapath responder plus fetch/issue scoreboard, all sampled on the falling edge
    initial begin
        int         issue_cyc = 0;
        bit         pend = 1'b0;
        logic [WW-1:0] pend_val = '0;
        int         last_f = 0;
        logic       halted_prev = 1'b0;
        fetch_t     f;
        issue_t     e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 1'b0; issue_cyc = 0; res_valid = 1'b0; res_data = '0;
                op_ready = 1'b1; halted_prev = 1'b0;
            end else begin
                if (inject_res) begin
                    res_valid = 1'b1; res_data = 20'h00777;
                end else if (pend) begin
                    res_valid = 1'b1; res_data = pend_val; pend = 1'b0;
                end else begin
                    res_valid = 1'b0;
                end
                if (imem_en) begin
                    if (fetch_q.size() == 0) begin
                        check("fetch_unexpected", imem_addr, 32'hFFFF_FFFF);
                    end else begin
                        f = fetch_q.pop_front();
                        check("fetch_addr", imem_addr, f.addr);
                        if (f.gap != 0) check("fetch_gap", cyc - last_f, f.gap);
                    end
                    last_f = cyc;
                end
                if (halted && !halted_prev) check("halt_latency", cyc - last_f, 2);
                halted_prev = halted;
                op_ready = !(op_valid && ((op_code == C_SADD && issue_cyc < 4) || op_code == C_NRDY));
                if (op_valid) begin
                    if (issue_q.size() == 0) begin
                        check("issue_unexpected", op_code, 32'hFFFF_FFFF);
                    end else begin
                        e = issue_q[0];
                        check("issue_code", op_code, e.code);
                        check("issue_a", op_a, e.a);
                        check("issue_b", op_b, e.b);
                        if (op_ready) begin
                            check("issue_latency", cyc - last_f, e.lat);
                            e = issue_q.pop_front();
                            if (op_code == C_LDC) pend_val = (ld_q.size() != 0) ? ld_q.pop_front() : '0;
                            else pend_val = op_a + op_b;
                            pend = (op_code != C_HANG);
                            issue_cyc = 0;
                        end else begin
                            issue_cyc++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        clr_mem();
        #12;
        check("rst_op_valid", op_valid, 0);
        check("rst_imem_en", imem_en, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_op_code", op_code, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        dbg_chk("rst_dbg_r0", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Run 1: loads, add, taken/not-taken branches, stalled issue, halt at pc 6
        imem[0]  = enc(C_LDC, 8, 8, 1);
        imem[1]  = enc(C_LDC, 8, 8, 2);
        imem[2]  = enc(C_ADD, 1, 2, 3);
        imem[3]  = enc(C_BRZ, 4, 9, 0);
        imem[9]  = enc(C_SADD, 3, 1, 5);
        imem[10] = enc(C_LDC, 8, 8, 4);
        imem[11] = enc(C_BRZ, 6, 3, 0);
        imem[6]  = enc(C_HALT, 0, 0, 0);
        ld_q.push_back(20'd5); ld_q.push_back(20'd7); ld_q.push_back(20'd1);
        push_i(C_LDC, 0, 0, 2);
        push_i(C_LDC, 0, 0, 2);
        push_i(C_ADD, 5, 7, 2);
        push_i(C_SADD, 12, 5, 6);
        push_i(C_LDC, 0, 0, 2);
        push_f(0, 0);  push_f(1, 5); push_f(2, 5); push_f(3, 5); push_f(9, 2);
        push_f(10, 9); push_f(11, 5); push_f(3, 2); push_f(4, 2); push_f(5, 2); push_f(6, 2);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();   // busy: must be ignored
        wait_halt();
        repeat (4) @(negedge clk);
        check("halt_busy", busy, 0);
        check("halt_still", halted, 1);
        check("run1_fetch_left", fetch_q.size(), 0);
        check("run1_issue_left", issue_q.size(), 0);
        dbg_chk("r1", 1, 5);
        dbg_chk("r2", 2, 7);
        dbg_chk("r3_add", 3, 12);
        dbg_chk("r4", 4, 1);
        dbg_chk("r5_sadd", 5, 17);

        // Run 2: restart from HALTED, pc wrap through NOP at 31, write to register 0
        clr_mem();
        imem[0]  = enc(C_BRZ, 7, 29, 0);
        imem[29] = enc(C_LDC, 8, 8, 0);
        imem[30] = enc(C_LDC, 8, 8, 7);
        imem[6]  = enc(C_HALT, 0, 0, 0);
        ld_q.push_back(20'h0ABCD); ld_q.push_back(20'd1);
        push_i(C_LDC, 0, 0, 2);
        push_i(C_LDC, 0, 0, 2);
        push_f(0, 0); push_f(29, 2); push_f(30, 5); push_f(31, 5); push_f(0, 2);
        for (int i = 1; i <= 6; i++) push_f(i, 2);
        pulse_start();
        wait_halt();
        repeat (2) @(negedge clk);
        check("run2_fetch_left", fetch_q.size(), 0);
        dbg_chk("r7", 7, 1);
`ifdef ISEQ_R0_ZERO_EN
        dbg_chk("r0_write", 0, 0);
`else
        dbg_chk("r0_write", 0, 20'h0ABCD);
`endif

        // Run 3a: asynchronous reset while an operation is being offered
        clr_mem();
        imem[0] = enc(C_LDC, 8, 8, 9);
        imem[1] = enc(C_NRDY, 9, 8, 11);
        ld_q.push_back(20'h00123);
        push_i(C_LDC, 0, 0, 2);
        push_i(C_NRDY, 20'h00123, 0, 2);
        push_f(0, 0); push_f(1, 5);
        pulse_start();
        n = 0;
        while (!(op_valid && op_code == C_NRDY) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("nrdy_offered", op_valid, 1);
        dbg_chk("r9_before_rst", 9, 20'h00123);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_op_valid", op_valid, 0);
        check("async_busy", busy, 0);
        check("async_op_a", op_a, 0);
        check("async_imem_en", imem_en, 0);
        dbg_chk("r9_after_rst", 9, 0);
        dbg_chk("r3_after_rst", 3, 0);
        issue_q.delete(); fetch_q.delete(); ld_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Run 3b: reset during WAIT, later result strobe must be ignored
        clr_mem();
        imem[0] = enc(C_HANG, 9, 9, 11);
        push_i(C_HANG, 0, 0, 2);
        push_f(0, 0);
        repeat (2) @(negedge clk);
        pulse_start();
        n = 0;
        while (issue_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hang_issued", issue_q.size(), 0);
        @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_op_valid", op_valid, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("wait_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        inject_res = 1'b1;
        repeat (2) @(negedge clk);
        inject_res = 1'b0;
        repeat (3) @(negedge clk);
        dbg_chk("r11_no_write", 11, 0);
        check("idle_after_rst_busy", busy, 0);
        check("idle_after_rst_halted", halted, 0);
        check("final_fetch_left", fetch_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
